lb2apb: RTL
===========

Name: lb2apb

Overview:
- Local-bus-to-APB initiator: accepts local bus (LB) write/read requests from a register-map-side master and executes them as APB3/APB4 transfers toward a peripheral.
- Opposite end of the apb2lb bridge: the LB side here is a responder (drives wready/rvalid/rdata) and the APB side is the requester (drives psel/penable).
- Sits between an internal LB master (CPU shim, SPI-to-LB bridge) and an APB-attached peripheral.

Parameters:
- ADDR_W, 32, LB and APB address width.
- DATA_W, 32, data width; multiple of 8.
- STRB_W, DATA_W/8, byte strobe width; derived, not overridden.
- TIMEOUT_CYCLES, 255, ACCESS cycles allowed before abort; used only with LB2APB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- waddr  in  ADDR_W  LB write address.
- wdata  in  DATA_W  LB write data.
- wstrb  in  STRB_W  LB write byte strobes.
- wen  in  1  LB write request; held with waddr/wdata/wstrb until wready.
- wready  out  1  one-cycle write-done pulse.
- raddr  in  ADDR_W  LB read address.
- ren  in  1  LB read request; held with raddr until rvalid.
- rdata  out  DATA_W  read data, valid while rvalid=1.
- rvalid  out  1  one-cycle read-done pulse.
- err  out  1  pulses with wready/rvalid when the transfer ended in error.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction, 1 = write.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  STRB_W  APB4 write strobes; all zeros on reads.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- One clock (clk); reset rst is asynchronous, active-high.
- Reset values:
  - All outputs 0: psel, penable, pwrite, paddr, pwdata, pstrb, wready, rvalid, rdata, err.
  - State IDLE.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, SETUP, ACCESS, WRESP, RRESP.
- IDLE:
  - If wen=1: capture waddr/wdata/wstrb into paddr/pwdata/pstrb, pwrite=1, psel=1, go to SETUP.
  - Else if ren=1: capture raddr into paddr, pstrb=0, pwrite=0, psel=1, go to SETUP.
  - wen and ren high together: write wins. The read stays pending and is served after the write completes.
- SETUP: one cycle, psel=1, penable=0. Then set penable=1 and go to ACCESS.
- ACCESS:
  - Hold psel=penable=1 and all APB address/data/control stable until pready=1.
  - On pready=1, drop psel and penable.
  - Write: go to WRESP, wready<=1.
  - Read: go to RRESP, rvalid<=1, rdata<=prdata.
  - err<=pslverr in both cases.
- WRESP and RRESP: single-cycle states with the response pulse high.
  - wen/ren are ignored here, so a request still asserted in the pulse cycle is not re-issued.
  - Then clear the pulse, force rdata to 0 and err to 0, and return to IDLE.
- Latency, LB request to LB response, in cycles: 3 + number of pready-low ACCESS cycles.
  - Zero-wait APB: request seen in IDLE at edge 0, SETUP, ACCESS, response pulse in cycle 3.
- Back-to-back: the earliest next APB SETUP is two cycles after the previous ACCESS completes (RESP, then IDLE).
- Requests arriving while the FSM is busy are not sampled until IDLE. The LB protocol keeps them held.
- Reset mid-transfer: everything returns to reset values immediately. The aborted LB request gets no response. After reset, a still-held request is re-issued from IDLE.
- paddr is passed through unmodified; no alignment is enforced.

Optional Feature:
- Macro: LB2APB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts ACCESS cycles with pready=0.
  - When it reaches TIMEOUT_CYCLES, the transfer is aborted: psel and penable drop.
  - The FSM then goes to WRESP or RRESP with err=1; rdata=0 for reads.
  - The counter clears on entry to SETUP.
- Not defined:
  - No counter; ACCESS waits for pready indefinitely.
  - err reflects pslverr only.

Test Plan:
- Write, zero-wait: wen with waddr=0x8000_0004, wdata=0xDEADBEEF, wstrb=0xF.
  -> One APB write with pstrb=0xF.
  -> wready pulses exactly 1 cycle, 3 cycles after the request; err=0.
- Byte-strobe write: waddr=0x00C, wdata=0xCAFEBABE, wstrb=0b0110.
  -> pstrb=0b0110; pwdata/paddr stable through ACCESS.
- Write with 800 pready-low cycles (timeout macro off):
  -> psel/penable held for 801 ACCESS cycles.
  -> Single wready pulse, no re-issue while wen is still high in the pulse cycle.
- Reads: raddr=0x014, slave returns 0xC0DEBABE with 0 waits.
  -> rvalid 1 cycle, rdata=0xC0DEBABE.
  -> Repeat with raddr=0x008, 0xDEADBEEF and 5 waits -> response at cycle 8.
- Simultaneous wen+ren (write 0x010 = 0x0ACCE55, read 0x014):
  -> APB write first, then APB read.
  -> Exactly one wready, then one rvalid; no overlap of psel.
- Error/timeout: slave pslverr=1 on a read -> rvalid with err=1.
  -> With LB2APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, and pready stuck low -> abort after 16 ACCESS cycles with err=1, rdata=0.
  -> Then assert rst mid-ACCESS -> all outputs 0 immediately.

Source files
------------

// File: rtl/lb2apb.sv
// lb2apb: local-bus (LB) to APB3/APB4 initiator.
//
// The LB side is a responder: a master holds wen (or ren) with its address,
// data and strobes until this block answers with a one-cycle wready (or
// rvalid) pulse. Each request becomes one APB transfer (SETUP then ACCESS).
// If wen and ren arrive together the write goes first and the read is
// served once the write has completed.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   waddr, wdata, wstrb, wen       LB write request
//   wready                         LB write-done pulse
//   raddr, ren                     LB read request
//   rdata, rvalid                  LB read data / read-done pulse
//   err                            error flag, pulses with wready/rvalid
//   psel, penable, pwrite, paddr,
//   pwdata, pstrb                  APB requester outputs (pstrb = 0 on reads)
//   prdata, pready, pslverr        APB completer inputs
//
// All outputs are registered.
//
// Optional feature macro: LB2APB_TIMEOUT_EN. When defined, an ACCESS phase
// that sees TIMEOUT_CYCLES cycles with pready low is aborted and answered
// with err=1 (rdata=0 on reads). When undefined, ACCESS waits indefinitely.

module lb2apb #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    localparam int STRB_W        = DATA_W / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wen,
    output logic              wready,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        WRESP  = 3'd3,
        RRESP  = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic                psel_r, psel_s;
    logic                penable_r, penable_s;
    logic                pwrite_r, pwrite_s;
    logic [ADDR_W-1:0]   paddr_r, paddr_s;
    logic [DATA_W-1:0]   pwdata_r, pwdata_s;
    logic [STRB_W-1:0]   pstrb_r, pstrb_s;
    logic                wready_r, wready_s;
    logic                rvalid_r, rvalid_s;
    logic [DATA_W-1:0]   rdata_r, rdata_s;
    logic                err_r, err_s;

`ifdef LB2APB_TIMEOUT_EN
    localparam int          CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Value of the counter during the last pready-low cycle before abort.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]       tmo_r, tmo_s;
`endif

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_s   = state_r;
        psel_s    = psel_r;
        penable_s = penable_r;
        pwrite_s  = pwrite_r;
        paddr_s   = paddr_r;
        pwdata_s  = pwdata_r;
        pstrb_s   = pstrb_r;
        wready_s  = wready_r;
        rvalid_s  = rvalid_r;
        rdata_s   = rdata_r;
        err_s     = err_r;
`ifdef LB2APB_TIMEOUT_EN
        tmo_s     = tmo_r;
`endif
        case (state_r)
            IDLE: begin
                // Write has priority; a simultaneous read stays pending on the LB.
                if (wen) begin
                    paddr_s  = waddr;
                    pwdata_s = wdata;
                    pstrb_s  = wstrb;
                    pwrite_s = 1'b1;
                    psel_s   = 1'b1;
                    state_s  = SETUP;
`ifdef LB2APB_TIMEOUT_EN
                    tmo_s    = '0;
`endif
                end else if (ren) begin
                    paddr_s  = raddr;
                    pstrb_s  = '0;
                    pwrite_s = 1'b0;
                    psel_s   = 1'b1;
                    state_s  = SETUP;
`ifdef LB2APB_TIMEOUT_EN
                    tmo_s    = '0;
`endif
                end else begin
                    state_s  = IDLE;
                end
            end
            SETUP: begin
                penable_s = 1'b1;
                state_s   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    psel_s    = 1'b0;
                    penable_s = 1'b0;
                    err_s     = pslverr;
                    if (pwrite_r) begin
                        wready_s = 1'b1;
                        state_s  = WRESP;
                    end else begin
                        rvalid_s = 1'b1;
                        rdata_s  = prdata;
                        state_s  = RRESP;
                    end
                end
`ifdef LB2APB_TIMEOUT_EN
                // Abort: this is the TIMEOUT_CYCLES-th cycle with pready low.
                else if (tmo_r == TMO_LAST) begin
                    psel_s    = 1'b0;
                    penable_s = 1'b0;
                    err_s     = 1'b1;
                    rdata_s   = '0;
                    if (pwrite_r) begin
                        wready_s = 1'b1;
                        state_s  = WRESP;
                    end else begin
                        rvalid_s = 1'b1;
                        state_s  = RRESP;
                    end
                end else begin
                    tmo_s = tmo_r + CNT_W'(1);
                end
`else
                else begin
                    state_s = ACCESS;
                end
`endif
            end
            WRESP, RRESP: begin
                // LB requests are not looked at here, so a request still held
                // during the response pulse is not issued a second time.
                wready_s = 1'b0;
                rvalid_s = 1'b0;
                rdata_s  = '0;
                err_s    = 1'b0;
                state_s  = IDLE;
            end
            default: begin
                psel_s    = 1'b0;
                penable_s = 1'b0;
                wready_s  = 1'b0;
                rvalid_s  = 1'b0;
                rdata_s   = '0;
                err_s     = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= '0;
            pwdata_r  <= '0;
            pstrb_r   <= '0;
            wready_r  <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            err_r     <= 1'b0;
`ifdef LB2APB_TIMEOUT_EN
            tmo_r     <= '0;
`endif
        end else begin
            state_r   <= state_s;
            psel_r    <= psel_s;
            penable_r <= penable_s;
            pwrite_r  <= pwrite_s;
            paddr_r   <= paddr_s;
            pwdata_r  <= pwdata_s;
            pstrb_r   <= pstrb_s;
            wready_r  <= wready_s;
            rvalid_r  <= rvalid_s;
            rdata_r   <= rdata_s;
            err_r     <= err_s;
`ifdef LB2APB_TIMEOUT_EN
            tmo_r     <= tmo_s;
`endif
        end
    end

    assign psel    = psel_r;
    assign penable = penable_r;
    assign pwrite  = pwrite_r;
    assign paddr   = paddr_r;
    assign pwdata  = pwdata_r;
    assign pstrb   = pstrb_r;
    assign wready  = wready_r;
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;
    assign err     = err_r;

endmodule
